acl_poll_scheduler: RTL and testbench
=====================================

// Module: acl_poll_scheduler
// PURPOSE
//  Sequences the accelerometer sample path: polls X/Y/Z round-robin over a shared req/ack sample port
//  at a fixed rate, applies threshold + hysteresis + debounce per axis, and posts one event at a time
//  to the consumer, which clears it with a read strobe. Sits between the accelerometer interface and
//  the text-display/event logic; replaces free-running threshold checks with a scheduled, handshaked flow.
// PARAMETERS
//  DATA_W    10     sample width, unsigned magnitude
//  THRESH    16     trigger level; sample > THRESH counts toward an event
//  HYST      4      re-arm level is THRESH-HYST; sample < THRESH-HYST resets the axis (requires HYST <= THRESH)
//  DEBOUNCE  3      consecutive above-threshold polls needed to fire (>=1)
//  POLL_DIV  50000  clk cycles between poll rounds (>=8)
//  TIMEOUT   255    max cycles waiting for smp_ack before abort
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  enable       in   1       1 = polling active
//  smp_req      out  1       sample request to shared sample port
//  smp_axis     out  2       axis being requested: 0=X 1=Y 2=Z
//  smp_ack      in   1       one-cycle strobe, smp_data valid in same cycle
//  smp_data     in   DATA_W  sample magnitude
//  evt_valid    out  1       event pending
//  evt_axis     out  2       axis that fired
//  evt_mag      out  DATA_W  sample value that fired
//  evt_read     in   1       consumer has read event
//  err_clr      in   1       clears timeout_err and overrun
//  timeout_err  out  1       sticky: an ack timed out
//  overrun      out  1       sticky: event dropped because evt_valid was still set
//  led          out  1       = evt_valid
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; poll/timeout counters 0; debounce counts 0; all axes armed.
//  Poll counter: runs while enable=1, counts 0..POLL_DIV-1 and wraps; tick = count==POLL_DIV-1. enable=0 clears it.
//  FSM: IDLE -> (tick) REQ, axis=0.
//   REQ: smp_req=1, smp_axis=axis; timeout counter increments per cycle. On smp_ack: capture smp_data,
//    smp_req drops next cycle, go EVAL. If counter reaches TIMEOUT with no ack: set timeout_err, smp_req=0,
//    abort round (later axes skipped), go IDLE. Ack arriving while smp_req=0 is ignored.
//   EVAL (1 cycle) for current axis: data > THRESH -> cnt = min(cnt+1, DEBOUNCE);
//    data < THRESH-HYST -> cnt=0, armed=1; otherwise cnt holds. Fire when cnt==DEBOUNCE and armed:
//    armed=0; if evt_valid=0 or evt_read=1 this cycle -> load evt_axis/evt_mag, evt_valid=1
//    (new event wins over same-cycle read); else set overrun, event dropped.
//    Then axis==2 -> IDLE, else axis+1 -> REQ.
//  Latency: ack to evt_valid = 2 cycles (capture, EVAL registers). Round = 3 handshakes + 3 EVAL cycles.
//  evt_read with evt_valid=1 -> evt_valid=0 next cycle; evt_read with evt_valid=0 ignored.
//  enable=0 mid-round: outstanding request completes or times out, then FSM returns to IDLE; no new rounds.
//  A tick arriving while a round is in progress is dropped (no queuing).
//  err_clr clears stickies next cycle; same-cycle set and clear -> set wins.
//  Comparisons unsigned, full DATA_W; debounce counters width clog2(DEBOUNCE+1), saturating.
//  rst_n low at any time aborts immediately, smp_req=0 asynchronously.
// TESTING (POLL_DIV=8, DEBOUNCE=2, THRESH=16, HYST=4, TIMEOUT=15)
//  1 enable=1, ack 2 cycles after each req, X data=20 two rounds, Y/Z=0 -> evt_valid=1 axis=0 mag=20
//    2 cycles after 2nd-round X ack; led=1.
//  2 X=20 held for 5 rounds, no evt_read -> exactly one event (disarmed); X=10 then X=20 x2 -> no re-fire
//    until evt_read; with evt_valid still set -> overrun=1.
//  3 X=14 (in hysteresis band) between two X=20 polls -> fires on 2nd X=20 (count held, not reset);
//    X=11 between -> no fire (count reset).
//  4 never ack on Y -> timeout_err=1 after 15 cycles, smp_req drops, Z not requested this round;
//    err_clr -> 0.
//  5 evt_read in same cycle as new fire on Z -> evt_valid stays 1, evt_axis=2, overrun=0.
//  6 rst_n low during WAIT on Y -> all outputs 0 immediately; after release first req only after next tick, axis=0.

Source files
------------

// File: rtl/acl_poll_scheduler_if.sv
// Sample-port and event-port handshake bundle between the poll scheduler,
// the accelerometer sample source and the event consumer.
interface acl_poll_scheduler_if #(
    parameter int DATA_W = 10
);
    logic              smp_req;
    logic [1:0]        smp_axis;
    logic              smp_ack;
    logic [DATA_W-1:0] smp_data;
    logic              evt_valid;
    logic [1:0]        evt_axis;
    logic [DATA_W-1:0] evt_mag;
    logic              evt_read;

    modport master (
        output smp_req, smp_axis, evt_valid, evt_axis, evt_mag,
        input  smp_ack, smp_data, evt_read
    );

    modport slave (
        input  smp_req, smp_axis, evt_valid, evt_axis, evt_mag,
        output smp_ack, smp_data, evt_read
    );
endinterface

// File: rtl/acl_poll_scheduler.sv
// Round-robin X/Y/Z accelerometer poller with per-axis threshold, hysteresis
// and debounce, posting one event at a time to a read-strobe consumer.
module acl_poll_scheduler #(
    parameter int DATA_W   = 10,
    parameter int THRESH   = 16,
    parameter int HYST     = 4,
    parameter int DEBOUNCE = 3,
    parameter int POLL_DIV = 50000,
    parameter int TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    acl_poll_scheduler_if.master bus,
    input  logic                 err_clr,
    output logic                 timeout_err,
    output logic                 overrun,
    output logic                 led
);
    localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(DEBOUNCE + 1);

    localparam logic [PW-1:0]     PMAX = PW'(POLL_DIV - 1);
    localparam logic [TW-1:0]     TMAX = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0]     DEB  = CW'(DEBOUNCE);
    localparam logic [DATA_W-1:0] TH   = DATA_W'(THRESH);
    localparam logic [DATA_W-1:0] LO   = DATA_W'(THRESH - HYST);

    typedef enum logic [1:0] {IDLE, REQ, EVAL} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     poll_cnt;
    logic              tick;
    logic [TW-1:0]     to_cnt;
    logic [1:0]        axis;
    logic [DATA_W-1:0] smp_p0;
    logic [CW-1:0]     deb_cnt [3];
    logic [2:0]        armed;
    logic              evt_valid_q;
    logic [1:0]        evt_axis_q;
    logic [DATA_W-1:0] evt_mag_q;

    logic              ack_hit;
    logic              to_hit;
    logic [CW-1:0]     cnt_cur;
    logic [CW-1:0]     cnt_nxt;
    logic              armed_cur;
    logic              above;
    logic              below;
    logic              fire;
    logic              evt_load;
    logic              evt_drop;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c >= DEB) ? c : c + CW'(1);
    endfunction

    assign tick    = enable && (poll_cnt == PMAX);
    assign ack_hit = (state == REQ) && bus.smp_ack;
    assign to_hit  = (state == REQ) && !bus.smp_ack && (to_cnt == TMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            poll_cnt <= '0;
        else if (!enable || poll_cnt == PMAX)
            poll_cnt <= '0;
        else
            poll_cnt <= poll_cnt + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A late tick is simply lost; disabling ends the round after the current axis.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (tick) state_nxt = REQ;
            REQ: begin
                if (bus.smp_ack)
                    state_nxt = EVAL;
                else if (to_hit)
                    state_nxt = IDLE;
            end
            EVAL: state_nxt = (axis == 2'd2 || !enable) ? IDLE : REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axis   <= 2'd0;
            to_cnt <= '0;
            smp_p0 <= '0;
        end else begin
            to_cnt <= ((state == REQ) && !bus.smp_ack) ? to_cnt + TW'(1) : '0;
            if (state == IDLE && tick)
                axis <= 2'd0;
            else if (state == EVAL && state_nxt == REQ)
                axis <= axis + 2'd1;
            if (ack_hit)
                smp_p0 <= bus.smp_data;
        end
    end

    // ---- EVAL stage: classify captured sample against the current axis state ----
    always_comb begin
        cnt_cur   = '0;
        armed_cur = 1'b0;
        unique case (axis)
            2'd0:    begin cnt_cur = deb_cnt[0]; armed_cur = armed[0]; end
            2'd1:    begin cnt_cur = deb_cnt[1]; armed_cur = armed[1]; end
            2'd2:    begin cnt_cur = deb_cnt[2]; armed_cur = armed[2]; end
            default: begin cnt_cur = '0;         armed_cur = 1'b0;     end
        endcase
        above   = smp_p0 > TH;
        below   = smp_p0 < LO;
        cnt_nxt = cnt_cur;
        if (above)
            cnt_nxt = sat_inc(cnt_cur);
        else if (below)
            cnt_nxt = '0;
        fire     = (state == EVAL) && armed_cur && (cnt_nxt == DEB);
        evt_load = fire && (!evt_valid_q || bus.evt_read);
        evt_drop = fire && !evt_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
            armed <= 3'b111;
        end else if (state == EVAL) begin
            for (int i = 0; i < 3; i++) begin
                if (axis == 2'(i)) begin
                    deb_cnt[i] <= cnt_nxt;
                    if (below)
                        armed[i] <= 1'b1;
                    else if (fire)
                        armed[i] <= 1'b0;
                end
            end
        end
    end

    // ---- event register: a new event takes priority over a same-cycle read ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid_q <= 1'b0;
            evt_axis_q  <= 2'd0;
            evt_mag_q   <= '0;
        end else if (evt_load) begin
            evt_valid_q <= 1'b1;
            evt_axis_q  <= axis;
            evt_mag_q   <= smp_p0;
        end else if (bus.evt_read) begin
            evt_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (to_hit)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;
            if (evt_drop)
                overrun <= 1'b1;
            else if (err_clr)
                overrun <= 1'b0;
        end
    end

    assign bus.smp_req   = (state == REQ);
    assign bus.smp_axis  = axis;
    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_axis  = evt_axis_q;
    assign bus.evt_mag   = evt_mag_q;
    assign led           = evt_valid_q;
endmodule

// File: tb/tb_acl_poll_scheduler.sv
// Directed bench for acl_poll_scheduler with small poll divider, debounce of 2
// and a 15-cycle ack timeout.
module tb_acl_poll_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic err_clr = 1'b0;
    logic timeout_err, overrun, led;
    int vectors = 0;
    int miscompares = 0;

    acl_poll_scheduler_if #(.DATA_W(10)) bus ();

    acl_poll_scheduler #(
        .DATA_W(10), .THRESH(16), .HYST(4), .DEBOUNCE(2), .POLL_DIV(8), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
        .err_clr(err_clr), .timeout_err(timeout_err), .overrun(overrun), .led(led)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0; err_clr = 1'b0;
        bus.smp_ack = 1'b0; bus.smp_data = '0; bus.evt_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits for a request, acks it two cycles later; returns in the EVAL cycle.
    task automatic serve(input logic [9:0] d, output logic ok, output logic [1:0] ax);
        int n = 0;
        ok = 1'b0; ax = 2'd3;
        while (!bus.smp_req && n < 200) begin @(negedge clk); n++; end
        if (bus.smp_req) begin
            ok = 1'b1; ax = bus.smp_axis;
            repeat (2) @(negedge clk);
            bus.smp_ack = 1'b1; bus.smp_data = d;
            @(negedge clk);
            bus.smp_ack = 1'b0; bus.smp_data = '0;
        end
    endtask

    task automatic round(input logic [9:0] dx, input logic [9:0] dy, input logic [9:0] dz,
                         output logic ok);
        logic o; logic [1:0] a;
        ok = 1'b1;
        serve(dx, o, a); if (!o || a != 2'd0) ok = 1'b0;
        serve(dy, o, a); if (!o || a != 2'd1) ok = 1'b0;
        serve(dz, o, a); if (!o || a != 2'd2) ok = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.smp_req, bus.smp_axis, bus.evt_valid, bus.evt_axis, bus.evt_mag,
             timeout_err, overrun, led} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got req=%b axis=%0d ev=%b eax=%0d mag=%0d to=%b ov=%b led=%b want all 0",
                     bus.smp_req, bus.smp_axis, bus.evt_valid, bus.evt_axis, bus.evt_mag,
                     timeout_err, overrun, led);
        end
    endtask

    task automatic test_detect();
        logic o; logic [1:0] a; logic ok;
        do_reset();
        enable = 1'b1;
        serve(10'd20, o, a);
        vectors++;
        if (o !== 1'b1 || a !== 2'd0) begin
            miscompares++; $display("FAIL detect_first_req got ok=%b axis=%0d want ok=1 axis=0", o, a);
        end
        serve(10'd0, o, a); serve(10'd0, o, a);
        vectors++;
        if (bus.evt_valid !== 1'b0) begin
            miscompares++; $display("FAIL detect_round1 got evt_valid=%b want 0", bus.evt_valid);
        end
        serve(10'd20, o, a);
        vectors++;
        if (bus.evt_valid !== 1'b0) begin
            miscompares++; $display("FAIL detect_latency1 got evt_valid=%b want 0 one cycle after ack", bus.evt_valid);
        end
        @(negedge clk);
        vectors++;
        if ({bus.evt_valid, bus.evt_axis, bus.evt_mag, led} !== {1'b1, 2'd0, 10'd20, 1'b1}) begin
            miscompares++;
            $display("FAIL detect_event got ev=%b axis=%0d mag=%0d led=%b want ev=1 axis=0 mag=20 led=1",
                     bus.evt_valid, bus.evt_axis, bus.evt_mag, led);
        end
        serve(10'd0, o, a); serve(10'd0, o, a);
        round(10'd0, 10'd0, 10'd0, ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++; $display("FAIL detect_round_order got ok=%b want 1 (X,Y,Z in order)", ok);
        end
    endtask

    task automatic test_disarm_overrun();
        logic ok; logic allok;
        do_reset();
        enable = 1'b1;
        allok = 1'b1;
        for (int r = 0; r < 5; r++) begin round(10'd20, 10'd0, 10'd0, ok); allok &= ok; end
        vectors++;
        if ({allok, bus.evt_valid, bus.evt_axis, bus.evt_mag, overrun} !== {1'b1, 1'b1, 2'd0, 10'd20, 1'b0}) begin
            miscompares++;
            $display("FAIL disarm_single got ok=%b ev=%b axis=%0d mag=%0d ov=%b want ok=1 ev=1 axis=0 mag=20 ov=0",
                     allok, bus.evt_valid, bus.evt_axis, bus.evt_mag, overrun);
        end
        round(10'd10, 10'd0, 10'd0, ok);
        round(10'd25, 10'd0, 10'd0, ok);
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++; $display("FAIL rearm_count1 got overrun=%b want 0", overrun);
        end
        round(10'd25, 10'd0, 10'd0, ok);
        vectors++;
        if ({overrun, bus.evt_valid, bus.evt_mag} !== {1'b1, 1'b1, 10'd20}) begin
            miscompares++;
            $display("FAIL overrun_drop got ov=%b ev=%b mag=%0d want ov=1 ev=1 mag=20",
                     overrun, bus.evt_valid, bus.evt_mag);
        end
        bus.evt_read = 1'b1;
        @(negedge clk);
        bus.evt_read = 1'b0;
        vectors++;
        if ({bus.evt_valid, led} !== 2'b00) begin
            miscompares++; $display("FAIL read_clears got ev=%b led=%b want 0 0", bus.evt_valid, led);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++; $display("FAIL overrun_clear got overrun=%b want 0", overrun);
        end
    endtask

    task automatic test_hysteresis();
        logic ok;
        do_reset();
        enable = 1'b1;
        round(10'd20, 10'd0, 10'd0, ok);
        round(10'd14, 10'd0, 10'd0, ok);
        vectors++;
        if (bus.evt_valid !== 1'b0) begin
            miscompares++; $display("FAIL hyst_band_nofire got evt_valid=%b want 0", bus.evt_valid);
        end
        round(10'd20, 10'd0, 10'd0, ok);
        vectors++;
        if ({bus.evt_valid, bus.evt_axis} !== {1'b1, 2'd0}) begin
            miscompares++; $display("FAIL hyst_band_hold got ev=%b axis=%0d want ev=1 axis=0", bus.evt_valid, bus.evt_axis);
        end
        do_reset();
        enable = 1'b1;
        round(10'd20, 10'd0, 10'd0, ok);
        round(10'd11, 10'd0, 10'd0, ok);
        round(10'd20, 10'd0, 10'd0, ok);
        vectors++;
        if (bus.evt_valid !== 1'b0) begin
            miscompares++; $display("FAIL hyst_below_reset got evt_valid=%b want 0", bus.evt_valid);
        end
        round(10'd20, 10'd0, 10'd0, ok);
        vectors++;
        if (bus.evt_valid !== 1'b1) begin
            miscompares++; $display("FAIL hyst_refire got evt_valid=%b want 1", bus.evt_valid);
        end
    endtask

    task automatic test_timeout();
        logic o; logic [1:0] a;
        int n; int reqs;
        do_reset();
        enable = 1'b1;
        serve(10'd0, o, a);
        n = 0;
        while (!bus.smp_req && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if ({bus.smp_req, bus.smp_axis} !== {1'b1, 2'd1}) begin
            miscompares++; $display("FAIL timeout_yreq got req=%b axis=%0d want 1 1", bus.smp_req, bus.smp_axis);
        end
        n = 0;
        while (bus.smp_req && n < 100) begin n++; @(negedge clk); end
        vectors++;
        if (n != 15 || timeout_err !== 1'b1) begin
            miscompares++; $display("FAIL timeout_len got req_cycles=%0d to=%b want 15 1", n, timeout_err);
        end
        n = 0;
        while (!bus.smp_req && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if ({bus.smp_req, bus.smp_axis} !== {1'b1, 2'd0}) begin
            miscompares++; $display("FAIL timeout_skipz got req=%b axis=%0d want 1 0", bus.smp_req, bus.smp_axis);
        end
        enable = 1'b0;
        serve(10'd0, o, a);
        reqs = 0;
        for (int i = 0; i < 30; i++) begin @(negedge clk); if (bus.smp_req) reqs++; end
        vectors++;
        if (reqs != 0 || timeout_err !== 1'b1) begin
            miscompares++; $display("FAIL disable_stop got req_cycles=%0d to=%b want 0 1", reqs, timeout_err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++; $display("FAIL timeout_clear got to=%b want 0", timeout_err);
        end
    endtask

    task automatic test_read_collision();
        logic ok;
        do_reset();
        enable = 1'b1;
        round(10'd20, 10'd0, 10'd21, ok);
        round(10'd20, 10'd0, 10'd21, ok);
        bus.evt_read = 1'b1;
        @(negedge clk);
        bus.evt_read = 1'b0;
        vectors++;
        if ({bus.evt_valid, bus.evt_axis, bus.evt_mag, overrun} !== {1'b1, 2'd2, 10'd21, 1'b0}) begin
            miscompares++;
            $display("FAIL read_collision got ev=%b axis=%0d mag=%0d ov=%b want ev=1 axis=2 mag=21 ov=0",
                     bus.evt_valid, bus.evt_axis, bus.evt_mag, overrun);
        end
        enable = 1'b0;
        bus.evt_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.evt_read = 1'b0;
        vectors++;
        if ({bus.evt_valid, overrun} !== 2'b00) begin
            miscompares++; $display("FAIL read_idle got ev=%b ov=%b want 0 0", bus.evt_valid, overrun);
        end
    endtask

    task automatic test_async_reset();
        logic ok; logic o; logic [1:0] a;
        int n;
        do_reset();
        enable = 1'b1;
        round(10'd20, 10'd0, 10'd0, ok);
        round(10'd20, 10'd0, 10'd0, ok);
        serve(10'd0, o, a);
        n = 0;
        while (!bus.smp_req && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if ({bus.smp_req, bus.smp_axis, bus.evt_valid} !== {1'b1, 2'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL areset_setup got req=%b axis=%0d ev=%b want 1 1 1", bus.smp_req, bus.smp_axis, bus.evt_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.smp_req, bus.smp_axis, bus.evt_valid, bus.evt_mag, led} !== 15'd0) begin
            miscompares++;
            $display("FAIL areset_immediate got req=%b axis=%0d ev=%b mag=%0d led=%b want all 0",
                     bus.smp_req, bus.smp_axis, bus.evt_valid, bus.evt_mag, led);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!bus.smp_req && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if (n != 8 || bus.smp_axis !== 2'd0) begin
            miscompares++; $display("FAIL areset_first_req got delay=%0d axis=%0d want 8 0", n, bus.smp_axis);
        end
        enable = 1'b0;
        serve(10'd0, o, a);
    endtask

    initial begin
        bus.smp_ack = 1'b0; bus.smp_data = '0; bus.evt_read = 1'b0;
        test_reset();
        test_detect();
        test_disarm_overrun();
        test_hysteresis();
        test_timeout();
        test_read_collision();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
